// File: rtl/apu_pkg.sv
// Shared APU definitions: wave modes, register map
// and the standard length-counter table.
package apu_pkg;

  typedef enum logic [1:0] {
    TRI    = 2'd0,
    SAW_UP = 2'd1,
    SAW_DN = 2'd2
  } wave_mode_t;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_PLO  = 2'd2;
  localparam logic [1:0] ADDR_PHI  = 2'd3;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,
    8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,
    8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,
    8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,
    8'd16,  8'd28,  8'd32,  8'd30
  };

endpackage

// File: rtl/apu_sysbus_if.sv
// APU register bus: write strobe, address, data.
// Sampled by channels on the system clock.
interface apu_sysbus_if;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data;

  modport master (output we, addr, data);
  modport slave  (input  we, addr, data);
endinterface

// File: rtl/apu_len_table.sv
// Combinational length-table lookup shared by
// all APU channels.
module apu_len_table
  import apu_pkg::*;
(
  input  logic [4:0] idx_i,
  output logic [7:0] len_o
);

  assign len_o = LEN_TABLE[idx_i];

endmodule

// File: rtl/apu_wave_gen.sv
// Wave channel: period timer, linear/length counters
// and a step sequencer with tri/saw output shapes.
module apu_wave_gen
  import apu_pkg::*;
#(
  parameter int unsigned TIMER_W = 11,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned LIN_W   = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  apu_sysbus_if.slave      sysbus_i,
  input  logic             sel_i,
  input  logic             en_i,
  input  logic             qframe_i,
  input  logic             hframe_i,
  output logic             act_o,
  output logic [OUT_W-1:0] out_o
);

  localparam int unsigned SEQ_W = OUT_W + 1;

  logic               en_q;
  logic               ctrl_q;
  logic [LIN_W-1:0]   lin_load_q;
  logic               mute_q;
  logic [1:0]         mode_q;
  logic [7:0]         per_lo_q;
  logic [2:0]         per_hi_q;
  logic [TIMER_W-1:0] timer_q;
  logic [LIN_W-1:0]   lin_q;
  logic               rld_q;
  logic [7:0]         len_q;
  logic [SEQ_W-1:0]   pos_q;

  logic               wr;
  logic               wr0, wr1, wr2, wr3;
  logic [10:0]        per_raw, per_wr_raw;
  logic [TIMER_W-1:0] period, per_wr;
  logic [7:0]         len_tab;
  logic               step, muted, adv;

  assign wr  = sel_i & sysbus_i.we & en_i;
  assign wr0 = wr & (sysbus_i.addr == ADDR_CTRL);
  assign wr1 = wr & (sysbus_i.addr == ADDR_MODE);
  assign wr2 = wr & (sysbus_i.addr == ADDR_PLO);
  assign wr3 = wr & (sysbus_i.addr == ADDR_PHI);

  assign per_raw    = {per_hi_q, per_lo_q};
  assign per_wr_raw = {sysbus_i.data[2:0], per_lo_q};
  assign period     = per_raw[TIMER_W-1:0];
  assign per_wr     = per_wr_raw[TIMER_W-1:0];

  apu_len_table u_len_table (
    .idx_i (sysbus_i.data[7:3]),
    .len_o (len_tab)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q       <= 1'b0;
      ctrl_q     <= 1'b0;
      lin_load_q <= '0;
      mute_q     <= 1'b0;
      mode_q     <= '0;
      per_lo_q   <= '0;
      per_hi_q   <= '0;
    end else if (!en_i) begin
      en_q       <= 1'b0;
      ctrl_q     <= 1'b0;
      lin_load_q <= '0;
      mute_q     <= 1'b0;
      mode_q     <= '0;
      per_lo_q   <= '0;
      per_hi_q   <= '0;
    end else begin
      en_q <= 1'b1;
      if (wr0) begin
        ctrl_q     <= sysbus_i.data[7];
        lin_load_q <= sysbus_i.data[LIN_W-1:0];
      end
      if (wr1) begin
        mute_q <= sysbus_i.data[7];
        mode_q <= sysbus_i.data[1:0];
      end
      if (wr2) per_lo_q <= sysbus_i.data;
      if (wr3) per_hi_q <= sysbus_i.data[2:0];
    end
  end

  assign step = (timer_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          timer_q <= '0;
    else if (!en_i)       timer_q <= '0;
    else if (wr3)         timer_q <= per_wr;
    else if (step)        timer_q <= period;
    else                  timer_q <= timer_q - 1'b1;
  end

  // reg3 write wins over the qframe clear of the reload flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lin_q <= '0;
      rld_q <= 1'b0;
    end else if (!en_i) begin
      lin_q <= '0;
      rld_q <= 1'b0;
    end else begin
      if (qframe_i) begin
        if (rld_q)       lin_q <= lin_load_q;
        else if (|lin_q) lin_q <= lin_q - 1'b1;
      end
      if (wr3)                      rld_q <= 1'b1;
      else if (qframe_i && !ctrl_q) rld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      len_q <= '0;
    else if (!en_i)   len_q <= '0;
    else if (wr3)     len_q <= len_tab;
    else if (hframe_i && !ctrl_q && |len_q)
      len_q <= len_q - 1'b1;
  end

  assign muted = mute_q & ~|period[TIMER_W-1:1];
  assign adv   = step & |lin_q & |len_q & ~muted;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    pos_q <= '0;
    else if (!en_i) pos_q <= '0;
    else if (adv)   pos_q <= pos_q + 1'b1;
  end

  always_comb begin
    out_o = '0;
    if (en_q) begin
      unique case (1'b1)
        (mode_q == SAW_UP): out_o = pos_q[SEQ_W-1:1];
        (mode_q == SAW_DN): out_o = ~pos_q[SEQ_W-1:1];
        default:
          out_o = {OUT_W{pos_q[SEQ_W-1]}}
                ^ pos_q[OUT_W-1:0];
      endcase
    end
  end

  assign act_o = |len_q;

endmodule

// File: tb/tb_apu_wave_gen.sv
// Directed bench for apu_wave_gen: expected samples
// are queued per driven clock and checked after it.
module tb_apu_wave_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel, en, qframe, hframe;
  logic       act;
  logic [3:0] out;

  int total = 0;
  int bad   = 0;
  logic [3:0] sb [$];

  apu_sysbus_if bus ();

  apu_wave_gen #(
    .TIMER_W (11),
    .OUT_W   (4),
    .LIN_W   (7)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sysbus_i (bus),
    .sel_i    (sel),
    .en_i     (en),
    .qframe_i (qframe),
    .hframe_i (hframe),
    .act_o    (act),
    .out_o    (out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    sel    = 1'b0;
    bus.we = 1'b0;
    qframe = 1'b0;
    hframe = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [7:0] d);
    sel      = 1'b1;
    bus.we   = 1'b1;
    bus.addr = a;
    bus.data = d;
    tick();
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [3:0] e;
    e = sb.pop_front();
    chk(tag, out, e);
  endtask

  function automatic logic [3:0] wave(input int pos,
                                      input int m);
    logic [4:0] p;
    p = pos[4:0];
    case (m)
      1:       return p[4:1];
      2:       return ~p[4:1];
      default: return {4{p[4]}} ^ p[3:0];
    endcase
  endfunction

  // j counts clocks since the reg3 write edge
  task automatic run_wave(input int p, input int m,
                          input int j0, input int n,
                          input string tag);
    for (int j = j0; j < j0 + n; j++) begin
      sb.push_back(wave((j + 1) / (p + 1), m));
      tick();
      pop_chk(tag);
    end
  endtask

  task automatic hold(input logic [3:0] v,
                      input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      sb.push_back(v);
      tick();
      pop_chk(tag);
    end
  endtask

  task automatic fresh(input logic [7:0] r0,
                       input logic [7:0] r1,
                       input logic [7:0] r2,
                       input logic [7:0] r3);
    en = 1'b0;
    tick();
    en = 1'b1;
    wr(2'd0, r0);
    wr(2'd1, r1);
    wr(2'd2, r2);
    chk("act_before_len", {3'b0, act}, 4'd0);
    wr(2'd3, r3);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    sel      = 1'b0;
    qframe   = 1'b0;
    hframe   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 2'd0;
    bus.data = 8'd0;
    #2;
    chk("rst_out", out, 4'd0);
    chk("rst_act", {3'b0, act}, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();

    fresh(8'h85, 8'h00, 8'h03, 8'h08);
    chk("act_rise", {3'b0, act}, 4'd1);
    qframe = 1'b1;
    run_wave(3, 0, 0, 132, "tri");

    rst_n = 1'b0;
    #1;
    chk("midrst_out", out, 4'd0);
    chk("midrst_act", {3'b0, act}, 4'd0);
    tick();
    rst_n = 1'b1;

    fresh(8'h85, 8'h01, 8'h03, 8'h08);
    qframe = 1'b1;
    run_wave(3, 1, 0, 132, "saw_up");

    fresh(8'h85, 8'h02, 8'h03, 8'h08);
    qframe = 1'b1;
    run_wave(3, 2, 0, 40, "saw_dn");
    en = 1'b0;
    tick();
    chk("en_off_out", out, 4'd0);
    chk("en_off_act", {3'b0, act}, 4'd0);

    fresh(8'h85, 8'h00, 8'h01, 8'h08);
    qframe = 1'b1;
    run_wave(1, 0, 0, 20, "us_off");
    wr(2'd1, 8'h80);
    chk("us_wr", out, 4'd10);
    hold(4'd10, 10, "us_mute");

    fresh(8'h02, 8'h00, 8'h03, 8'h08);
    qframe = 1'b1;
    run_wave(3, 0, 0, 8, "lin_a");
    qframe = 1'b1;
    run_wave(3, 0, 8, 8, "lin_b");
    qframe = 1'b1;
    hold(4'd4, 12, "lin_halt");

    fresh(8'h82, 8'h00, 8'h03, 8'h08);
    for (int c = 0; c < 5; c++) begin
      qframe = 1'b1;
      run_wave(3, 0, 8 * c, 8, "lin_ctrl");
    end

    fresh(8'h05, 8'h00, 8'h03, 8'h18);
    chk("len_load", {3'b0, act}, 4'd1);
    hframe = 1'b1;
    tick();
    chk("len_h1", {3'b0, act}, 4'd1);
    hframe = 1'b1;
    tick();
    chk("len_h2", {3'b0, act}, 4'd0);

    hframe = 1'b1;
    wr(2'd3, 8'h18);
    chk("len_coinc", {3'b0, act}, 4'd1);
    hframe = 1'b1;
    tick();
    chk("len_coinc_h1", {3'b0, act}, 4'd1);
    hframe = 1'b1;
    tick();
    chk("len_coinc_h2", {3'b0, act}, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apu_wave_gen.md
# apu_wave_gen

Parametrised successor to the APU triangle channel: a wave generator with a programmable period timer, a linear counter, a length counter and a step sequencer. It adds selectable waveform modes (triangle, rising saw, falling saw), an ultrasonic-mute option, and generic timer and output widths. The whole block runs in the `sys.clk` domain, with quarter-frame and half-frame strobes used as clock enables. It sits beside the other APU channels on `sysbus` and feeds the APU mixer.

## Interface
- `TIMER_W`, default 11: period timer width, range 8..11. Period is `{reg3[2:0], reg2}` truncated to `TIMER_W`.
- `OUT_W`, default 4: output sample width. Sequencer width is `SEQ_W = OUT_W+1`, giving `2^SEQ_W` steps.
- `LIN_W`, default 7: linear counter width, range 1..7. Loaded from `reg0[LIN_W-1:0]`.
- `sys.clk`  input  1  system clock; all state changes on posedge.
- `sys.n_reset`  input  1  reset, asynchronous, active-low.
- `sysbus`  interface  —  `we`, `addr[1:0]`, `data[7:0]` are sampled on posedge `sys.clk`.
- `sel`  input  1  channel register select.
- `en`  input  1  channel enable (status register bit).
- `qframe`  input  1  single-cycle quarter-frame strobe, synchronous to `sys.clk`.
- `hframe`  input  1  single-cycle half-frame strobe, synchronous to `sys.clk`.
- `act`  output  1  length counter is non-zero.
- `out`  output  `OUT_W`  sample.

## Operation
- Write strobe: `wr = sel & sysbus.we`.
- Registers:
  - reg0: `{ctrl, lin_load}`. `ctrl` also acts as length-halt.
  - reg1: `{mute_us, 5'b0, mode[1:0]}`. Mode 0 = triangle, 1 = rising saw, 2 = falling saw, 3 = triangle.
  - reg2: period low byte.
  - reg3: `{len_idx[4:0], period_hi[2:0]}`.
- While `en=0`: all registers, timer, linear counter, length counter, reload flag and sequencer position are held at 0.
- Timer:
  - Each clock: if it is 0 or reg3 is written, reload with period; otherwise decrement.
  - `step = (timer==0)`, evaluated before the update.
- Linear counter, updated on `qframe`:
  - If `reload_flag` is set, load `lin_load`; otherwise, if non-zero, decrement.
  - Then, if `ctrl=0`, clear `reload_flag`.
  - A reg3 write sets `reload_flag`. A write coinciding with `qframe` leaves the flag set.
- Length counter:
  - A reg3 write with `en=1` loads `len_table[len_idx]` in the same clock.
  - Otherwise, on `hframe` with `ctrl=0` and count ≠ 0, decrement.
  - A load coinciding with `hframe` wins; there is no decrement that cycle.
- Sequencer:
  - Position `pos[SEQ_W-1:0]` increments, wrapping at `2^SEQ_W-1 → 0`, when all of these hold: `step`, linear ≠ 0, length ≠ 0, and not ultrasonic-muted.
  - Ultrasonic-muted means `mute_us=1 && period<2`.
  - When halted, `pos` holds and `out` holds its last value. There is no snap to 0.
- Output:
  - `en=0`: `out = 0`.
  - Triangle: `{OUT_W{pos[MSB]}} ^ pos[OUT_W-1:0]`, giving 0…max,max…0.
  - Rising saw: `pos[SEQ_W-1:1]`.
  - Falling saw: `~pos[SEQ_W-1:1]`.
  - A mode change applies on the next clock, with no position reset.
- `act = (length ≠ 0)`.

## Timing
- Reset values: all registers, counters, `reload_flag` and `pos` are 0, so `out=0` and `act=0` asynchronously.
- Register write visible one clock after the write edge.
- `out` is combinational from registered `pos`/`mode`/`en`. It changes one clock after a `step` edge.
- Output step period = `(period+1)` clocks. The first step after a reg3 write comes `period+1` clocks later.
- `act` rises the clock after a reg3 write with non-zero table entry. It falls the clock after the `hframe` that decrements the count to 0.
- A `qframe` and `hframe` in the same cycle are both serviced. Linear and length logic are independent.

## Structure
- `apu_pkg` holds:
  - the `wave_mode_t` enum (`TRI`, `SAW_UP`, `SAW_DN`);
  - register address constants;
  - the 32-entry standard NES length table as a constant array (`LEN_TABLE`, 8-bit).
- `apu_len_table` is a combinational lookup sub-module, with no ROM latency. It is shared with the other channels.
- Everything else lives in one module with separate always_ff blocks for timer, linear counter, length counter and sequencer.

## Test plan
- **Reset:** assert `n_reset=0` mid-operation → `out=0`, `act=0` immediately. After release with `en=1`, reg0=0x85, reg2=0x03, reg3=0x08 (`len_idx` 1 → 254) → `act=1` the next clock. After the next `qframe`, `out` steps 0,1,2… every 4 clocks. Wrap check: the 16th step gives 15, and the triangle returns 15…0.
- **Rising saw:** reg1=0x01, period 3 → `out` sequence 0,0,1,1,…,15,15,0 on steps.
- **Ultrasonic mute:** reg1=0x80, period 1 → `pos` frozen and `out` held at its last value. With reg1=0x00, the same period steps every 2 clocks.
- **Linear counter:** reg0=0x02 (`ctrl=0`), reg3 write, then 3 `qframe` pulses → the sequencer runs for 2 quarter-frames, then halts with `out` held. With `ctrl=1`, it reloads on every `qframe` and never halts.
- **Length counter:** reg3 `len_idx=3` (→2), `ctrl=0` → `act` drops after the second `hframe`. A reg3 write in the same cycle as `hframe` → count equals the table value with no decrement. Drop `en` → all state cleared and `out=0` next clock.
